rng_word_packer: RTL and testbench
==================================

// Module: rng_word_packer
// PURPOSE
//   Consumes the 1-bit/cycle pseudorandom stream of the LFSR generator (its r output) and packs
//   it into WIDTH-bit words. Words are buffered in a small FIFO and presented downstream on a
//   valid/ready handshake. Sits between the serial PRNG and any SoC consumer of random words.
// PARAMETERS
//   WIDTH  8  bits per packed output word (>=2)
//   DEPTH  4  FIFO entries; power of two, >=2
//   CNT_W  8  width of saturating dropped-word counter
// PORTS
//   clk        in   1                 single clock, rising edge
//   reset      in   1                 synchronous, active-high
//   bit_in     in   1                 serial random bit (from generator r)
//   bit_valid  in   1                 bit_in is sampled this cycle when 1
//   clear      in   1                 sync flush: partial word + FIFO + debias state
//   out_data   out  WIDTH             FIFO head word (show-ahead)
//   out_valid  out  1                 FIFO non-empty
//   out_ready  in   1                 consumer accepts head when out_valid&&out_ready
//   level      out  $clog2(DEPTH)+1   FIFO occupancy 0..DEPTH
//   overflow   out  1                 sticky: a completed word was dropped
//   drop_cnt   out  CNT_W             dropped words, saturates at all-ones
// BEHAVIOUR
//   - Reset/clear (reset wins if both): bit count=0, shift reg=0, FIFO empty, out_valid=0,
//     out_data=0, level=0; reset also clears overflow and drop_cnt; clear does NOT clear them.
//     Bits presented in a reset/clear cycle are discarded.
//   - Packing: on accepted bit, shreg <= {shreg[WIDTH-2:0], bit}; first bit lands at MSB of word.
//     Counter 0..WIDTH-1; on accepting bit with count==WIDTH-1 the word is complete, count wraps 0.
//   - Latency: word completing on edge t is written into FIFO on edge t; out_valid high in the
//     cycle after t if FIFO was empty. Packing never stalls; bits are never back-pressured.
//   - Push when full: if pop occurs same cycle, push accepted (level unchanged); else word
//     dropped, overflow<=1, drop_cnt++ (saturating). Push when empty + pop: impossible (no valid).
//   - Pop: out_valid&&out_ready advances head; out_data shows next entry next cycle; out_data
//     holds last value when empty (only reset/clear zero it).
//   - level: +1 push only, -1 pop only, unchanged for both/neither. Pointers wrap mod DEPTH.
//   - out_data/out_valid are registered from FIFO storage; no combinational in->out path.
// CONFIGURATION
//   VON_NEUMANN_EN defined: accepted bits pass through debiaser first. Pair register holds first
//     bit of a pair; on second bit: 01->emit 0, 10->emit 1 (emit first bit), 00/11->emit nothing.
//     Only emitted bits feed the packer (avg throughput <=1/4 bit/cycle). clear/reset empty pair.
//   Undefined: every accepted bit feeds packer directly (1 bit/cycle).
// STRUCTURE
//   rng_pkg: localparam defaults, typedef word_t (logic [WIDTH-1:0]) for default width,
//     function clog2-based LEVEL_W.
//   Sub-module rng_word_fifo (WIDTH, DEPTH): sync show-ahead FIFO with push/pop/full/empty/level,
//     simultaneous push+pop when full supported. Packer, debiaser, overflow logic in top.
// TESTING
//   1 Reset, bit_valid=1, bits 1,0,1,1,0,0,1,0, out_ready=0 -> out_valid=1 cycle after 8th bit,
//     out_data=8'hB2, level=1; out_ready=1 one cycle -> out_valid=0, level=0.
//   2 bit_valid toggled 1,0,1,0... with same 8 bits -> same 8'hB2; gaps do not shift.
//   3 out_ready=0, 40 ones -> level=4, fifth word dropped, overflow=1, drop_cnt=1;
//     out_ready=1 then drains 4x 8'hFF; overflow stays 1 until reset.
//   4 FIFO full, 8th bit of new word with out_ready=1 same cycle -> no drop, level stays 4,
//     new word appears last after 3 more pops.
//   5 Feed 5 bits then clear, then 8'h3C serially -> only 8'h3C emitted; reset mid-word with
//     2 words queued -> out_valid=0, level=0, drop_cnt=0 next cycle.
//   6 VON_NEUMANN_EN: pairs 01,10,00,11 x4 -> 8 emitted bits 0,1 x4 -> out_data=8'h55;
//     without macro same 32 bits -> words 8'h63, 8'h63, 8'h63, 8'h63.

Source files
------------

// File: rtl/rng_word_packer_pkg.sv
// Shared defaults for the random word packer: parameter defaults, the
// default word type and the FIFO occupancy width helper.
package rng_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [WIDTH_DEF-1:0] word_t;

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rng_word_packer_if.sv
// Downstream word handshake of the packer.
// out_valid/out_ready: a word transfers on every rising clk edge where both
// are high; out_valid never depends combinationally on out_ready and, once
// high, stays high with out_data stable until the transfer happens.
interface rng_word_packer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/rng_word_packer_fifo.sv
// rng_word_fifo: synchronous show-ahead FIFO with a registered head word.
// The head register is updated alongside the storage so that dout is always
// the oldest entry, holds its last value once the FIFO drains, and only
// reset/flush zero it. Push while full is accepted when a pop happens in the
// same cycle.
module rng_word_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [LW-1:0]    cnt;
    logic [WIDTH-1:0] dout_q;
    logic             do_push;
    logic             do_pop;
    logic [PW-1:0]    rd_nxt;

    // Accepted push/pop qualification and the slot following the head.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != LW'(DEPTH)) || do_pop);
        rd_nxt  = rd_ptr + PW'(1);
    end

    // Storage write; a flushed cycle writes nothing.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            dout_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_nxt;
            if (do_push && !do_pop)      cnt <= cnt + LW'(1);
            else if (do_pop && !do_push) cnt <= cnt - LW'(1);
            if (cnt == '0) begin
                if (do_push) dout_q <= din;
            end else if (do_pop) begin
                // With one entry left, the next head is the word being pushed now.
                if (cnt == LW'(1)) begin
                    if (do_push) dout_q <= din;
                end else begin
                    dout_q <= mem[rd_nxt];
                end
            end
        end
    end

    assign dout  = dout_q;
    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/rng_word_packer.sv
// rng_word_packer: packs a 1-bit/cycle random stream into WIDTH-bit words
// (first bit at the MSB), buffers them in a small FIFO and counts words lost
// to a full FIFO. Optional macro VON_NEUMANN_EN inserts a von Neumann
// debiaser in front of the packer.
module rng_word_packer
    import rng_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    input  logic                      clear,
    rng_word_packer_if.master         dn,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic             feed_valid;
    logic             feed_bit;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    logic [WIDTH-1:0] fifo_dout;

`ifdef VON_NEUMANN_EN
    logic pair_full;
    logic pair_bit;

    // Pair register: first bit of a pair waits here for its partner.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
        end else if (bit_valid) begin
            pair_full <= !pair_full;
            if (!pair_full) pair_bit <= bit_in;
        end
    end

    // A differing pair emits its first bit; equal pairs emit nothing.
    always_comb begin
        feed_valid = bit_valid && pair_full && (pair_bit != bit_in);
        feed_bit   = pair_bit;
    end
`else
    // Every accepted bit goes straight to the packer.
    always_comb begin
        feed_valid = bit_valid;
        feed_bit   = bit_in;
    end
`endif

    // Word completion and the word as it will look after this bit.
    always_comb begin
        word_done = feed_valid && (bit_cnt == BW'(WIDTH - 1));
        word      = {shreg[WIDTH-2:0], feed_bit};
        pop       = dn.out_valid && dn.out_ready;
        drop      = word_done && full && !pop;
    end

    // Shift register and bit counter; packing never stalls.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (feed_valid) begin
            shreg   <= word;
            bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
        end
    end

    // Sticky overflow and saturating drop counter; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    rng_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (word_done),
        .din   (word),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign dn.out_data  = fifo_dout;
    assign dn.out_valid = !empty;

endmodule

// File: tb/tb_rng_word_packer.sv
// Directed bench for rng_word_packer: packing, gaps, overflow, full-with-pop,
// clear/reset and the optional debiaser build.
module tb_rng_word_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;
    int         n_cmp  = 0;
    int         n_fail = 0;

    rng_word_packer_if #(.WIDTH(8)) dn_if ();

    rng_word_packer #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear     (clear),
        .dn        (dn_if),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pop_one();
        dn_if.out_ready = 1'b1;
        tick();
        dn_if.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b2;
        logic [7:0] w5a;
        logic [7:0] pat;
        b2  = 8'hB2;
        w5a = 8'h5A;
        pat = 8'h63;
        reset = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        dn_if.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", dn_if.out_valid, 0);
        check("rst_data", dn_if.out_data, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);

`ifndef VON_NEUMANN_EN
        // 1: contiguous bits 1,0,1,1,0,0,1,0
        for (int i = 7; i >= 1; i--) send_bit(b2[i]);
        check("t1_not_yet", dn_if.out_valid, 0);
        send_bit(b2[0]);
        check("t1_valid", dn_if.out_valid, 1);
        check("t1_data", dn_if.out_data, 8'hB2);
        check("t1_level", level, 1);
        pop_one();
        check("t1_pop_valid", dn_if.out_valid, 0);
        check("t1_pop_level", level, 0);
        check("t1_hold_data", dn_if.out_data, 8'hB2);

        // 2: same bits with idle gaps
        for (int i = 7; i >= 0; i--) begin
            send_bit(b2[i]);
            tick();
        end
        check("t2_valid", dn_if.out_valid, 1);
        check("t2_data", dn_if.out_data, 8'hB2);
        check("t2_level", level, 1);
        pop_one();

        // 3: forty ones with no consumer
        for (int i = 0; i < 40; i++) send_bit(1'b1);
        check("t3_level", level, 4);
        check("t3_ovf", overflow, 1);
        check("t3_drop", drop_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_valid", dn_if.out_valid, 1);
            check("t3_drain_data", dn_if.out_data, 8'hFF);
            pop_one();
        end
        check("t3_empty", level, 0);
        check("t3_ovf_sticky", overflow, 1);

        // 4: full FIFO, last bit of a new word lands with a pop
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        check("t4_full", level, 4);
        for (int i = 7; i >= 1; i--) send_bit(w5a[i]);
        dn_if.out_ready = 1'b1;
        send_bit(w5a[0]);
        dn_if.out_ready = 1'b0;
        check("t4_level", level, 4);
        check("t4_no_drop", drop_cnt, 1);
        check("t4_head", dn_if.out_data, 8'h22);
        pop_one();
        check("t4_pop1", dn_if.out_data, 8'h33);
        pop_one();
        check("t4_pop2", dn_if.out_data, 8'h44);
        pop_one();
        check("t4_last", dn_if.out_data, 8'h5A);
        check("t4_last_level", level, 1);
        pop_one();
        check("t4_drained", dn_if.out_valid, 0);
        check("t4_hold", dn_if.out_data, 8'h5A);

        // 5: clear mid-word, then reset with words queued
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        clear = 1'b0; bit_valid = 1'b0;
        check("t5_clr_level", level, 0);
        check("t5_clr_data", dn_if.out_data, 0);
        check("t5_clr_drop", drop_cnt, 1);
        check("t5_clr_ovf", overflow, 1);
        send_word(8'h3C);
        check("t5_word", dn_if.out_data, 8'h3C);
        check("t5_word_level", level, 1);
        pop_one();
        send_word(8'hA5);
        send_word(8'h0F);
        check("t5_two", level, 2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        reset = 1'b0; bit_valid = 1'b0;
        check("t5_rst_valid", dn_if.out_valid, 0);
        check("t5_rst_level", level, 0);
        check("t5_rst_drop", drop_cnt, 0);
        check("t5_rst_ovf", overflow, 0);
        send_word(8'h81);
        check("t5_after_rst", dn_if.out_data, 8'h81);
        pop_one();

        // 6: the pair pattern without debiasing packs to 8'h63 words
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        end
        check("t6_level", level, 4);
        check("t6_drop", drop_cnt, 0);
        for (int k = 0; k < 4; k++) begin
            check("t6_data", dn_if.out_data, 8'h63);
            pop_one();
        end
        check("t6_empty", dn_if.out_valid, 0);
`else
        // 6: pairs 01,10,00,11 x4 emit 0,1 x4
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        end
        check("vn_valid", dn_if.out_valid, 1);
        check("vn_data", dn_if.out_data, 8'h55);
        check("vn_level", level, 1);
        pop_one();
        check("vn_empty", dn_if.out_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
